// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage of the 16-bit RISC core.
//
// Reads the PC, fetches the instruction word over a req/ack memory
// handshake and holds it in the instruction register until decode takes it.
// Sends increment/load strobes back to the PC and handles branch redirects,
// including redirects that land while a memory read is still outstanding.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   enable         fetching permitted; low finishes the current work, then idles
//   pc_in          current PC register value
//   pc_incr        PC increment strobe (combinational)
//   pc_ld, pc_din  PC load strobe and value (combinational, mirror redirect)
//   redirect       one-cycle branch/jump pulse
//   redirect_addr  branch/jump target
//   mem_req        registered read request, held until mem_ack
//   mem_addr       registered read address, stable while mem_req is high
//   mem_ack        read complete, mem_rdata valid in the same cycle
//   mem_rdata      instruction word from memory
//   ir, ir_pc      instruction register and the address it came from
//   ir_valid       ir holds an instruction for decode
//   ir_ready       decode accepts ir this cycle
//
// Handshakes: a transfer happens in a cycle where valid (mem_req / ir_valid)
// and its acceptance (mem_ack / ir_ready) are both high. A raised mem_req
// never drops and never changes mem_addr until the cycle that carries
// mem_ack (reset excepted). ir_valid stays high with ir stable until
// ir_ready or a redirect.
//
// The FSM state is held in the signal `state` (type state_t) for checkers.

module fetch_unit #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [AW-1:0] pc_in,
  output logic          pc_incr,
  output logic          pc_ld,
  output logic [AW-1:0] pc_din,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          restart;       // leave the current state: start a new fetch or idle
  logic [AW-1:0] restart_addr;  // address for that new fetch
  logic          ir_ld;         // non-squashed ack: capture the instruction

  // PC strobes. The redirect always wins, so a squashed ack never increments.
  assign pc_ld   = redirect & ~reset;
  assign pc_din  = redirect_addr;
  assign pc_incr = (state == REQ) & mem_ack & ~redirect & ~reset;

  always_comb begin
    state_nx     = state;
    restart      = 1'b0;
    restart_addr = pc_in;
    ir_ld        = 1'b0;

    case (state)
      IDLE: begin
        if (redirect) begin
          restart      = 1'b1;
          restart_addr = redirect_addr;
        end else if (enable) begin
          restart      = 1'b1;
          restart_addr = pc_in;
        end
      end

      REQ: begin
        if (mem_ack) begin
          if (redirect) begin
            restart      = 1'b1;
            restart_addr = redirect_addr;
          end else begin
            ir_ld    = 1'b1;
            state_nx = HOLD;
          end
        end else if (redirect) begin
          // The read is already out; let it finish, then drop its data.
          state_nx = DRAIN;
        end
      end

      HOLD: begin
        if (redirect) begin
          restart      = 1'b1;
          restart_addr = redirect_addr;
        end else if (ir_ready) begin
          // The PC was incremented on the ack edge, so pc_in is the next address.
          restart      = 1'b1;
          restart_addr = pc_in;
        end
      end

      DRAIN: begin
        if (mem_ack) begin
          // pc_in already holds the latest target; a redirect arriving with
          // the stale ack is newer still and is loaded into the PC this edge.
          restart      = 1'b1;
          restart_addr = redirect ? redirect_addr : pc_in;
        end
      end

      default: state_nx = IDLE;
    endcase

    if (restart) begin
      state_nx = enable ? REQ : IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      mem_req  <= (state_nx == REQ) || (state_nx == DRAIN);
      ir_valid <= (state_nx == HOLD);
      if (restart && enable) begin
        mem_addr <= restart_addr;
      end
      if (ir_ld) begin
        ir    <= mem_rdata;
        ir_pc <= mem_addr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// The bench owns the PC register and the instruction memory (word at
// address a is a + 0x1000). The reference model is the program-order
// instruction stream: starting at 0 (or a redirect target), decode must
// see consecutive addresses, each with its memory word. The driver pushes
// that stream into exp_q and restarts it on every redirect or reset; the
// monitor pops one entry per accepted instruction. The monitor also checks
// the PC strobes and the memory handshake rules cycle by cycle.

module tb_fetch_unit;

  localparam int AW = 16;
  localparam int DW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] pc_in;
  logic          pc_incr;
  logic          pc_ld;
  logic [AW-1:0] pc_din;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready;

  always #5 clk = ~clk;

  fetch_unit #(.AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .pc_in         (pc_in),
    .pc_incr       (pc_incr),
    .pc_ld         (pc_ld),
    .pc_din        (pc_din),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready)
  );

  // PC register upstream of the fetch unit.
  logic [AW-1:0] pc_model;
  assign pc_in = pc_model;

  always @(posedge clk or posedge reset) begin
    if (reset)        pc_model <= '0;
    else if (pc_ld)   pc_model <= pc_din;
    else if (pc_incr) pc_model <= pc_model + 1'b1;
  end

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  int hs_count    = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    push_addr;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return DW'(a) + 16'h1000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({push_addr, word_of(push_addr)});
      push_addr = push_addr + 1'b1;
    end
  endtask

  task automatic restart_stream(input logic [AW-1:0] a);
    exp_q.delete();
    push_addr = a;
    refill();
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit en, input int ack_pct, input int rdy_pct, input int redir_pct);
    @(posedge clk);
    #1;
    enable        = en;
    mem_ack       = mem_req && ($urandom_range(0, 99) < ack_pct);
    mem_rdata     = mem_ack ? word_of(mem_addr) : DW'($urandom);
    ir_ready      = ($urandom_range(0, 99) < rdy_pct);
    redirect      = ($urandom_range(0, 99) < redir_pct);
    redirect_addr = AW'($urandom_range(0, 255));
    if (redirect) restart_stream(redirect_addr);
    else          refill();
  endtask

  // ---------------- monitor ----------------
  logic          prev_valid = 1'b0;
  logic          prev_req, prev_ack, prev_good, prev_redir, prev_irv, prev_hs;
  logic [AW-1:0] prev_addr, prev_irpc;
  logic [DW-1:0] prev_ir;
  logic          squashed = 1'b0;
  logic          good;
  logic [AW+DW-1:0] exp_entry;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      squashed   = 1'b0;
    end else begin
      // An ack counts only if no redirect hit its request or its own cycle.
      good = mem_req && mem_ack && !redirect && !squashed;
      check("pc_ld", pc_ld, redirect);
      check("pc_din", pc_din, redirect_addr);
      check("incr_ld_excl", pc_incr && pc_ld, 0);
      check("pc_incr", pc_incr, good);
      check("req_vs_valid", mem_req && ir_valid, 0);

      if (prev_valid) begin
        if (prev_req && !prev_ack) begin
          check("req_held", mem_req, 1);
          check("addr_held", mem_addr, prev_addr);
        end
        if (prev_good) begin
          check("ir_valid_after_ack", ir_valid, 1);
          check("ir_load", ir, word_of(prev_addr));
          check("ir_pc_load", ir_pc, prev_addr);
        end else begin
          check("ir_kept", ir, prev_ir);
          check("ir_pc_kept", ir_pc, prev_irpc);
          check("ir_valid", ir_valid, prev_irv && !prev_hs && !prev_redir);
        end
      end

      // A new request must fetch from the PC as it stands after the edge.
      if (mem_req && (!prev_valid || !prev_req || prev_ack)) begin
        check("req_addr", mem_addr, pc_model);
      end

      if (ir_valid && ir_ready && !redirect) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL handoff: got %h/%h expected nothing pending", ir_pc, ir);
        end else begin
          exp_entry = exp_q.pop_front();
          check("handoff", {ir_pc, ir}, exp_entry);
        end
      end

      prev_valid = 1'b1;
      prev_req   = mem_req;
      prev_ack   = mem_ack;
      prev_addr  = mem_addr;
      prev_good  = good;
      prev_redir = redirect;
      prev_irv   = ir_valid;
      prev_hs    = ir_valid && ir_ready;
      prev_ir    = ir;
      prev_irpc  = ir_pc;
      if (mem_req && mem_ack)       squashed = 1'b0;
      else if (mem_req && redirect) squashed = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    mem_ack       = 1'b0;
    mem_rdata     = '0;
    ir_ready      = 1'b0;
    push_addr     = '0;

    // Reset values; PC strobes stay low even with redirect asserted.
    #1;
    redirect = 1'b1;
    #1;
    check("rst_ir", ir, 0);
    check("rst_ir_pc", ir_pc, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_pc_ld", pc_ld, 0);
    check("rst_pc_incr", pc_incr, 0);
    redirect = 1'b0;

    // Release; cycle 0 is IDLE with enable high.
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    enable   = 1'b1;
    ir_ready = 1'b1;
    restart_stream('0);

    // Cycle 1: first request at address 0, acked at once.
    @(posedge clk);
    #1;
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 0);
    mem_ack   = 1'b1;
    mem_rdata = word_of(mem_addr);

    // Cycle 2: instruction held for decode.
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("first_ir_valid", ir_valid, 1);
    check("first_ir", ir, 16'h1000);

    for (int i = 0; i < 20 && hs_count < 3; i++) drive(1'b1, 100, 100, 0);
    check("three_fetches", hs_count, 3);
    check("pc_after_three", pc_model, 3);

    // Random traffic: ack delays, decode stalls, redirects, enable drops.
    repeat (3000) drive($urandom_range(0, 9) != 0, 40, 60, 8);

    // Reset pulsed while an instruction is held.
    for (int i = 0; i < 50 && !ir_valid; i++) drive(1'b1, 100, 0, 0);
    check("hold_before_reset", ir_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_ir_valid", ir_valid, 0);
    check("midrst_ir", ir, 0);
    check("midrst_mem_req", mem_req, 0);
    check("midrst_pc_incr", pc_incr, 0);
    check("midrst_pc", pc_model, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    enable   = 1'b1;
    redirect = 1'b0;
    mem_ack  = 1'b0;
    restart_stream('0);
    @(posedge clk);
    #1;
    check("restart_req", mem_req, 1);
    check("restart_addr", mem_addr, 0);

    repeat (500) drive(1'b1, 50, 70, 5);

    // Drop enable: outstanding work finishes and the unit goes quiet.
    repeat (30) drive(1'b0, 100, 100, 0);
    check("stopped_req", mem_req, 0);
    check("stopped_valid", ir_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
